// File: rtl/result_sched_pkg.sv
// Shared types and helpers for the result display scheduler.
package result_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_DATA_W = 4;
  localparam int MAX_REQ    = 8;
  localparam int MAX_IDX_W  = 3;

  // Returns an 8-bit one-hot vector; callers truncate it to N_REQ bits.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: the lowest set request at or after ptr wins, wrapping
// modulo N_REQ. Tying ptr to zero gives fixed lowest-index priority.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  logic [N_REQ-1:0] req_rot;
  logic [IDX_W-1:0] offset;
  logic [IDX_W:0]   sum;

  // Rotating right by ptr puts the search start at bit 0.
  assign req_rot = N_REQ'({req, req} >> ptr);
  assign any_req = |req;

  // NOTE: every variable gets a default before any conditional assignment, so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    offset = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = IDX_W'(i);
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (IDX_W + 1)'(N_REQ)) sum = sum - (IDX_W + 1)'(N_REQ);
    winner = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/result_display_scheduler.sv
// Shares one DATA_W-bit display path between N_REQ producers; each granted
// result is held for HOLD_CYCLES clocks. Define ROUND_ROBIN_EN for round-robin
// arbitration, otherwise the lowest requesting index always wins.
module result_display_scheduler
  import result_sched_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data,
  output logic [N_REQ-1:0]        grant,
  output logic [DATA_W-1:0]       temp_results,
  output logic                    disp_valid,
  output logic                    busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [DATA_W-1:0] temp_q, temp_d;
  logic              disp_valid_q, disp_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [IDX_W-1:0]  arb_ptr;
  logic [IDX_W-1:0]  winner;
  logic              any_req;
  logic [DATA_W-1:0] win_data;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (req),
    .ptr     (arb_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == IDX_W'(i)) win_data = data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = '0;
    temp_d       = temp_q;
    disp_valid_d = disp_valid_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d      = N_REQ'(onehot(MAX_IDX_W'(winner)));
          temp_d       = win_data;
          disp_valid_d = 1'b1;
          cnt_d        = CNT_W'(HOLD_CYCLES - 1);
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          disp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      temp_q       <= '0;
      disp_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      temp_q       <= temp_d;
      disp_valid_q <= disp_valid_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] win_q, win_d;

  // The pointer moves past the last winner only when its hold finishes.
  always_comb begin
    ptr_d = ptr_q;
    win_d = win_q;
    if (state_q == IDLE && any_req) win_d = winner;
    if (state_q == HOLD && cnt_q == '0) begin
      ptr_d = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      win_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      win_q <= win_d;
    end
  end

  assign arb_ptr = ptr_q;
`else
  assign arb_ptr = '0;
`endif

  assign grant        = grant_q;
  assign temp_results = temp_q;
  assign disp_valid   = disp_valid_q;
  assign busy         = (state_q == HOLD);

endmodule

// File: tb/tb_result_display_scheduler.sv
// Directed bench for result_display_scheduler: a HOLD_CYCLES=3 instance for the
// main sequences and a HOLD_CYCLES=1 instance for the minimum display length.
module tb_result_display_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, req1;
  logic [15:0] data, data1;
  logic [3:0]  grant, grant1;
  logic [3:0]  temp_results, temp_results1;
  logic        disp_valid, disp_valid1;
  logic        busy, busy1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] exp_grant [5];
  logic [3:0] exp_temp  [5];

  always #5 clk = ~clk;

  result_display_scheduler #(.N_REQ(4), .DATA_W(4), .HOLD_CYCLES(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .data         (data),
    .grant        (grant),
    .temp_results (temp_results),
    .disp_valid   (disp_valid),
    .busy         (busy)
  );

  result_display_scheduler #(.N_REQ(4), .DATA_W(4), .HOLD_CYCLES(1)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .req          (req1),
    .data         (data1),
    .grant        (grant1),
    .temp_results (temp_results1),
    .disp_valid   (disp_valid1),
    .busy         (busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
`ifdef ROUND_ROBIN_EN
    exp_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_temp  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
`else
    exp_grant = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    exp_temp  = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
`endif
    req   = '0;
    req1  = '0;
    data  = '0;
    data1 = '0;
    @(negedge clk);
    do_reset();

    check("reset_grant", grant, 4'b0000);
    check("reset_temp", temp_results, 4'h0);
    check("reset_valid", disp_valid, 1'b0);
    check("reset_busy", busy, 1'b0);

    // All four requesting continuously: 3 HOLD cycles plus 1 IDLE per grant.
    data = 16'h4321;
    req  = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      check($sformatf("arb_grant%0d", g), grant, exp_grant[g]);
      check($sformatf("arb_temp%0d", g), temp_results, exp_temp[g]);
      check($sformatf("arb_valid%0d", g), disp_valid, 1'b1);
      for (int c = 1; c <= 3; c++) begin
        tick();
        check($sformatf("arb_gap_grant%0d_%0d", g, c), grant, 4'b0000);
        check($sformatf("arb_gap_valid%0d_%0d", g, c), disp_valid, (c < 3) ? 1'b1 : 1'b0);
      end
    end
    req = '0;
    do_reset();

    // Single request, data changed mid-hold.
    data = 16'h0900;
    req  = 4'b0100;
    tick();
    req = '0;
    check("single_grant", grant, 4'b0100);
    check("single_temp", temp_results, 4'h9);
    check("single_valid1", disp_valid, 1'b1);
    check("single_busy", busy, 1'b1);
    data = 16'h0300;
    tick();
    check("single_grant_pulse", grant, 4'b0000);
    check("single_valid2", disp_valid, 1'b1);
    check("single_temp_held", temp_results, 4'h9);
    tick();
    check("single_valid3", disp_valid, 1'b1);
    tick();
    check("single_valid_low", disp_valid, 1'b0);
    check("single_busy_low", busy, 1'b0);
    check("single_temp_idle", temp_results, 4'h9);
    tick();
    check("single_idle_hold", temp_results, 4'h9);
    check("single_idle_grant", grant, 4'b0000);

    // Request raised during another requester's hold waits for IDLE.
    data = 16'h7050;
    req  = 4'b0010;
    tick();
    check("late_first_grant", grant, 4'b0010);
    check("late_first_temp", temp_results, 4'h5);
    req = 4'b1000;
    tick();
    check("late_hold_grant", grant, 4'b0000);
    tick();
    tick();
    check("late_idle_valid", disp_valid, 1'b0);
    check("late_idle_grant", grant, 4'b0000);
    tick();
    req = '0;
    check("late_grant", grant, 4'b1000);
    check("late_temp", temp_results, 4'h7);
    tick();
    tick();
    tick();
    check("late_done", disp_valid, 1'b0);

    // Reset in the second HOLD cycle aborts the display.
    data = 16'h000A;
    req  = 4'b0001;
    tick();
    req = '0;
    check("abort_grant", grant, 4'b0001);
    check("abort_temp", temp_results, 4'hA);
    tick();
    rst = 1'b1;
    tick();
    check("abort_rst_temp", temp_results, 4'h0);
    check("abort_rst_valid", disp_valid, 1'b0);
    check("abort_rst_busy", busy, 1'b0);
    check("abort_rst_grant", grant, 4'b0000);
    rst = 1'b0;

    // One-cycle display with a continuous request.
    data1 = 16'h000C;
    req1  = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("h1_valid%0d", k), disp_valid1, (k % 2 == 0) ? 1'b1 : 1'b0);
      check($sformatf("h1_grant%0d", k), grant1, (k % 2 == 0) ? 4'b0001 : 4'b0000);
    end
    check("h1_temp", temp_results1, 4'hC);
    req1 = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
